// File: rtl/imem_responder.sv
// imem_responder: responder end of the instruction-fetch interface.
// Accepts PC fetches over valid/ready, reads a word-addressed instruction RAM through a
// fixed-latency pipeline, and returns instructions in order from a credit-managed response
// FIFO. A flush drops everything in flight; a write port loads the program image.
// Optional feature macro: IMEM_ERR_EN adds resp_err (out-of-range or misaligned fetch).
module imem_responder #(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_instr,
  output logic [31:0] resp_addr,
`ifdef IMEM_ERR_EN
  output logic        resp_err,
`endif
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + LATENCY) + 1;
  localparam logic [32:0] AddrLimit = 33'(DEPTH) << 2;
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          req_in_range;
  logic          load_in_range;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] load_idx;
  logic [31:0]   rd_data;

  logic          push_valid;
  logic [31:0]   push_addr;
  logic [31:0]   push_data;
  logic [CW-1:0] pipe_cnt;
  logic [CW-1:0] outstanding;

  logic [31:0]   fifo_addr  [FIFO_DEPTH];
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic          pop;

`ifdef IMEM_ERR_EN
  logic          rd_err;
  logic          push_err;
  logic          fifo_err [FIFO_DEPTH];
`endif

  assign req_in_range  = {1'b0, req_addr} < AddrLimit;
  assign load_in_range = {1'b0, load_addr} < AddrLimit;
  assign req_idx       = req_addr[AW+1:2];
  assign load_idx      = load_addr[AW+1:2];

  // Credits cover every entry already headed for the FIFO, so a push can never overflow it.
  assign outstanding = pipe_cnt + CW'(cnt_q);
  assign req_ready   = (outstanding < CW'(FIFO_DEPTH)) && !flush;
  assign accept      = req_valid && req_ready;

  assign resp_valid = (cnt_q != '0);
  assign pop        = resp_valid && resp_ready;
  assign resp_instr = resp_valid ? fifo_instr[rd_ptr_q] : '0;
  assign resp_addr  = resp_valid ? fifo_addr[rd_ptr_q] : '0;
`ifdef IMEM_ERR_EN
  assign resp_err   = resp_valid ? fifo_err[rd_ptr_q] : 1'b0;
`endif

  // Word lookup for the request being accepted; unserviceable addresses become NOP.
  always_comb begin
    rd_data = Nop;
`ifdef IMEM_ERR_EN
    rd_err = 1'b1;
    if (req_in_range && (req_addr[1:0] == 2'b00)) begin
      rd_data = mem[req_idx];
      rd_err  = 1'b0;
    end
`else
    if (req_in_range) begin
      rd_data = mem[req_idx];
    end
`endif
  end

  // Program load; the fetch path sees the pre-edge word, giving read-before-write.
  always_ff @(posedge clk) begin
    if (load_we && load_in_range) begin
      mem[load_idx] <= load_data;
    end
  end

  // The FIFO write is the last of the LATENCY registers, so only LATENCY-1 stages live here.
  if (LATENCY == 1) begin : g_direct
    assign push_valid = accept;
    assign push_addr  = req_addr;
    assign push_data  = rd_data;
`ifdef IMEM_ERR_EN
    assign push_err   = rd_err;
`endif
    assign pipe_cnt   = '0;
  end else begin : g_pipe
    localparam int unsigned NS = LATENCY - 1;

    logic [NS-1:0] valid_q;
    logic [31:0]   addr_q [NS];
    logic [31:0]   data_q [NS];
`ifdef IMEM_ERR_EN
    logic          err_q [NS];
`endif

    // Stage valid bits: cleared by reset or flush, otherwise shift one stage per cycle.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_q <= '0;
      end else if (flush) begin
        valid_q <= '0;
      end else begin
        valid_q[0] <= accept;
        for (int i = 1; i < NS; i++) begin
          valid_q[i] <= valid_q[i-1];
        end
      end
    end

    // Stage payload: stage 1 registers the RAM read, later stages just forward it.
    always_ff @(posedge clk) begin
      addr_q[0] <= req_addr;
      data_q[0] <= rd_data;
`ifdef IMEM_ERR_EN
      err_q[0]  <= rd_err;
`endif
      for (int i = 1; i < NS; i++) begin
        addr_q[i] <= addr_q[i-1];
        data_q[i] <= data_q[i-1];
`ifdef IMEM_ERR_EN
        err_q[i]  <= err_q[i-1];
`endif
      end
    end

    // Number of live stages, part of the credit count.
    always_comb begin
      pipe_cnt = '0;
      for (int i = 0; i < NS; i++) begin
        pipe_cnt = pipe_cnt + CW'(valid_q[i]);
      end
    end

    assign push_valid = valid_q[NS-1];
    assign push_addr  = addr_q[NS-1];
    assign push_data  = data_q[NS-1];
`ifdef IMEM_ERR_EN
    assign push_err   = err_q[NS-1];
`endif
  end

  // FIFO storage; contents need no reset because the outputs are gated by resp_valid.
  always_ff @(posedge clk) begin
    if (push_valid) begin
      fifo_addr[wr_ptr_q]  <= push_addr;
      fifo_instr[wr_ptr_q] <= push_data;
`ifdef IMEM_ERR_EN
      fifo_err[wr_ptr_q]   <= push_err;
`endif
    end
  end

  // FIFO pointers and occupancy; flush empties it and wins over a same-cycle pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_valid) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_valid, pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed plus randomized fetch traffic against a transaction-level
// reference: a shadow RAM and a queue of expected responses, each with the cycle at which
// it may first appear at the head.
module tb_imem_responder;

  localparam int unsigned DEPTH      = 1024;
  localparam int unsigned LATENCY    = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_instr;
  logic [31:0] resp_addr;
`ifdef IMEM_ERR_EN
  logic        resp_err;
`endif
  logic        load_we = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;

  always #5 clk = ~clk;

  imem_responder #(
    .DEPTH      (DEPTH),
    .LATENCY    (LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_instr (resp_instr),
    .resp_addr  (resp_addr),
`ifdef IMEM_ERR_EN
    .resp_err   (resp_err),
`endif
    .load_we    (load_we),
    .load_addr  (load_addr),
    .load_data  (load_data)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
    int          avail;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] ref_mem [DEPTH];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          dut_accepts = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_read(input logic [31:0] a, output logic [31:0] ins,
                                     output logic e);
    if (a >= 32'(4 * DEPTH)) begin
      ins = NOP;
      e   = 1'b1;
    end
`ifdef IMEM_ERR_EN
    else if (a[1:0] != 2'b00) begin
      ins = NOP;
      e   = 1'b1;
    end
`endif
    else begin
      ins = ref_mem[int'(a >> 2)];
      e   = (a[1:0] != 2'b00);
    end
  endfunction

  // One clock cycle: check outputs mid-cycle against the model, then advance the model.
  task automatic tick();
    logic exp_ready;
    logic exp_valid;
    logic pop;
    logic acc;
    rsp_t r;
    @(negedge clk);
    exp_ready = (q.size() < FIFO_DEPTH) && !flush;
    exp_valid = (q.size() > 0) && (q[0].avail <= cyc);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("resp_valid", 32'(resp_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("resp_instr", resp_instr, q[0].instr);
      chk("resp_addr", resp_addr, q[0].addr);
`ifdef IMEM_ERR_EN
      chk("resp_err", 32'(resp_err), 32'(q[0].err));
`endif
    end
    if (req_valid && req_ready) dut_accepts++;
    pop = exp_valid && resp_ready;
    acc = req_valid && exp_ready;
    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        model_read(req_addr, r.instr, r.err);
        r.addr  = req_addr;
        r.avail = cyc + LATENCY;
        q.push_back(r);
      end
    end
    if (load_we && (load_addr < 32'(4 * DEPTH))) ref_mem[int'(load_addr >> 2)] = load_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    load_we   = 1'b0;
    flush     = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [31:0] prog [4];
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h0010_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h0000_006F;

    // Reset values
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_instr", resp_instr, 32'd0);
    chk("rst_resp_addr", resp_addr, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Program image: 4 instructions, then random words up to index 63
    load_we = 1'b1;
    for (int i = 0; i < 64; i++) begin
      load_addr = 32'(i * 4);
      load_data = (i < 4) ? prog[i] : $urandom;
      tick();
    end
    load_we = 1'b0;

    // Back-to-back fetches with the consumer always ready
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'(i * 4);
      tick();
    end
    idle(4);

    // Back-pressure: only FIFO_DEPTH of 6 requests get in
    resp_ready  = 1'b0;
    req_valid   = 1'b1;
    dut_accepts = 0;
    for (int i = 0; i < 6; i++) begin
      req_addr = 32'((i % 4) * 4);
      tick();
    end
    chk("bp_accepts", 32'(dut_accepts), 32'(FIFO_DEPTH));
    req_valid  = 1'b0;
    tick();
    resp_ready = 1'b1;
    idle(6);

    // Flush with 3 in flight, a request held during the flush cycle
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = 32'(i * 4);
      tick();
    end
    dut_accepts = 0;
    flush       = 1'b1;
    req_addr    = 32'hC;
    tick();
    chk("flush_accepts", 32'(dut_accepts), 32'd0);
    flush      = 1'b0;
    resp_ready = 1'b1;
    req_addr   = 32'h8;
    tick();
    req_valid = 1'b0;
    idle(4);

    // Out-of-range and misaligned fetches
    req_valid = 1'b1;
    req_addr  = 32'(4 * DEPTH);
    tick();
    req_addr  = 32'h6;
    tick();
    req_addr  = 32'hFFFF_FFFC;
    tick();
    idle(4);

    // Load and fetch of the same word in one cycle
    req_valid = 1'b1;
    req_addr  = 32'h8;
    load_we   = 1'b1;
    load_addr = 32'h8;
    load_data = 32'hDEAD_BEEF;
    tick();
    load_we = 1'b0;
    tick();
    idle(4);

    // Out-of-range load must not alias onto a real word
    load_we   = 1'b1;
    load_addr = 32'(4 * DEPTH) + 32'h4;
    load_data = 32'hBAD0_BAD0;
    tick();
    load_we   = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h4;
    tick();
    idle(4);

    // Asynchronous reset with FIFO_DEPTH responses outstanding
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'(i * 4);
      tick();
    end
    req_valid = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_resp_valid", 32'(resp_valid), 32'd0);
    chk("arst_resp_instr", resp_instr, 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc += 2;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'(i * 4);
      tick();
    end
    idle(4);

    // Randomized traffic: fetches, back-pressure, loads and occasional flushes
    for (int n = 0; n < 800; n++) begin
      int sel;
      req_valid  = ($urandom_range(0, 3) != 0);
      resp_ready = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 31) == 0);
      sel        = int'($urandom_range(0, 15));
      if (sel < 13)       req_addr = 32'($urandom_range(0, 255));
      else if (sel < 15)  req_addr = 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
      else                req_addr = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
      load_we = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) != 0) load_addr = 32'($urandom_range(0, 63) * 4);
      else                           load_addr = 32'(4 * DEPTH) + 32'($urandom_range(0, 63) * 4);
      load_data = $urandom;
      tick();
    end
    resp_ready = 1'b1;
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
